ibex_rvfi_trace_fifo: RTL

IBEX_RVFI_TRACE_FIFO -- requirements
Module: ibex_rvfi_trace_fifo

---
 rtl/ibex_rvfi_trace_fifo.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ibex_rvfi_trace_fifo.sv
// ibex_rvfi_trace_fifo
//
// Captures retired-instruction records from the RVFI port into a small FIFO
// for a trace consumer. Every captured retirement consumes a sequence number,
// including ones dropped because the FIFO is full, so the consumer can spot
// gaps. The entry pushed after one or more drops carries a lost marker.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   trace_en_i          capture enable (draining continues when low)
//   clear_i             synchronous flush of FIFO, counters and flags
//   rvfi_*              retirement record from the core
//   trace_valid_o/ready handshake for the head entry
//   trace_*_o           head entry fields, sequence number and lost marker
//   drop_cnt_o          saturating count of dropped retirements
//   overflow_o          sticky, set on the first drop
//
// Depth must be a power of two and at least 2.

module ibex_rvfi_trace_fifo #(
    parameter int unsigned Depth    = 8,
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                trace_en_i,
    input  logic                clear_i,
    input  logic                rvfi_valid,
    input  logic [31:0]         rvfi_pc_rdata,
    input  logic [31:0]         rvfi_insn,
    input  logic                rvfi_trap,
    input  logic [4:0]          rvfi_rd_addr,
    input  logic [31:0]         rvfi_rd_wdata,
    output logic                trace_valid_o,
    input  logic                trace_ready_i,
    output logic [31:0]         trace_pc_o,
    output logic [31:0]         trace_insn_o,
    output logic [4:0]          trace_rd_addr_o,
    output logic [31:0]         trace_rd_wdata_o,
    output logic                trace_trap_o,
    output logic [CntWidth-1:0] trace_seq_o,
    output logic                trace_lost_o,
    output logic [CntWidth-1:0] drop_cnt_o,
    output logic                overflow_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam logic [AddrW:0]      PtrOne = 1;
    localparam logic [CntWidth-1:0] CntOne = 1;

    typedef struct packed {
        logic [31:0]         pc;
        logic [31:0]         insn;
        logic [4:0]          rd_addr;
        logic [31:0]         rd_wdata;
        logic                trap;
        logic [CntWidth-1:0] seq;
        logic                lost;
    } entry_t;

    entry_t              mem [Depth];
    entry_t              head;
    logic [AddrW:0]      wr_ptr;
    logic [AddrW:0]      rd_ptr;
    logic [CntWidth-1:0] seq_q;
    logic [CntWidth-1:0] drop_q;
    logic                overflow_q;
    logic                lost_pending_q;

    logic empty;
    logic full;
    logic capture;
    logic pop;
    logic push;
    logic drop;

    // Extra pointer MSB distinguishes full from empty when low bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AddrW] != rd_ptr[AddrW]) &&
                     (wr_ptr[AddrW-1:0] == rd_ptr[AddrW-1:0]);

    assign capture = rvfi_valid && trace_en_i && !clear_i;
    assign pop     = !empty && trace_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    // Storage is not reset; contents are ignored while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[AddrW-1:0]] <= '{
                pc:       rvfi_pc_rdata,
                insn:     rvfi_insn,
                rd_addr:  rvfi_rd_addr,
                rd_wdata: rvfi_rd_wdata,
                trap:     rvfi_trap,
                seq:      seq_q,
                lost:     lost_pending_q
            };
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            seq_q          <= '0;
            drop_q         <= '0;
            overflow_q     <= 1'b0;
            lost_pending_q <= 1'b0;
        end else if (clear_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            seq_q          <= '0;
            drop_q         <= '0;
            overflow_q     <= 1'b0;
            lost_pending_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr         <= wr_ptr + PtrOne;
                lost_pending_q <= 1'b0;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrOne;
            end
            if (capture) begin
                seq_q <= seq_q + CntOne;
            end
            if (drop) begin
                if (drop_q != '1) begin
                    drop_q <= drop_q + CntOne;
                end
                overflow_q     <= 1'b1;
                lost_pending_q <= 1'b1;
            end
        end
    end

    // Head is read straight from registered storage; no path from rvfi_*.
    assign head             = mem[rd_ptr[AddrW-1:0]];
    assign trace_valid_o    = !empty;
    assign trace_pc_o       = head.pc;
    assign trace_insn_o     = head.insn;
    assign trace_rd_addr_o  = head.rd_addr;
    assign trace_rd_wdata_o = head.rd_wdata;
    assign trace_trap_o     = head.trap;
    assign trace_seq_o      = head.seq;
    assign trace_lost_o     = head.lost;
    assign drop_cnt_o       = drop_q;
    assign overflow_o       = overflow_q;

endmodule
